// File: rtl/contador_caixas_param_if.sv
// Bottle/box handshake bundle between the line controller (master) and the
// packing counter (slave). Widths must match the counter's parameters.
interface contador_caixas_param_if #(
  parameter int WIDTH      = 4,
  parameter int BOX_WIDTH  = 8,
  parameter int LOSS_WIDTH = 8
);

  // Line side -> counter
  logic                  ENABLE;
  logic                  CLEAR;
  logic                  CAIXA_ACK;

  // Counter -> line side
  logic                  ENTRADA_PRONTA;
  logic [WIDTH-1:0]      COUNT;
  logic                  DUZIA_COMPLETA;
  logic                  CAIXA_PRONTA;
  logic [BOX_WIDTH-1:0]  CAIXAS;
  logic                  LOTE_COMPLETO;
  logic [LOSS_WIDTH-1:0] PERDAS;

  modport master (
    output ENABLE,
    output CLEAR,
    output CAIXA_ACK,
    input  ENTRADA_PRONTA,
    input  COUNT,
    input  DUZIA_COMPLETA,
    input  CAIXA_PRONTA,
    input  CAIXAS,
    input  LOTE_COMPLETO,
    input  PERDAS
  );

  modport slave (
    input  ENABLE,
    input  CLEAR,
    input  CAIXA_ACK,
    output ENTRADA_PRONTA,
    output COUNT,
    output DUZIA_COMPLETA,
    output CAIXA_PRONTA,
    output CAIXAS,
    output LOTE_COMPLETO,
    output PERDAS
  );

endinterface

// File: rtl/contador_caixas_param.sv
// Parametrised bottle-packing counter: bottles into boxes of PACK_SIZE, boxes
// into lots of LOT_SIZE, with a box hand-off handshake and a saturating loss count.
module contador_caixas_param #(
  parameter int WIDTH      = 4,   // 2 <= PACK_SIZE <= 2**WIDTH
  parameter int PACK_SIZE  = 12,
  parameter int BOX_WIDTH  = 8,   // 1 <= LOT_SIZE <= 2**BOX_WIDTH
  parameter int LOT_SIZE   = 10,
  parameter int LOSS_WIDTH = 8
) (
  input  logic                     CLOCK,
  input  logic                     RESET,
  contador_caixas_param_if.slave   bus
);

  localparam logic [WIDTH-1:0]      LAST_BOTTLE = WIDTH'(PACK_SIZE - 1);
  localparam logic [BOX_WIDTH-1:0]  LAST_BOX    = BOX_WIDTH'(LOT_SIZE - 1);
  localparam logic [LOSS_WIDTH-1:0] LOSS_MAX    = '1;

  // A closed box is either handed off (idle) or waiting for the sealing stage.
  typedef enum logic {
    BOX_IDLE    = 1'b0,
    BOX_PENDING = 1'b1
  } box_state_t;

  box_state_t box_state, box_state_next;

  logic [WIDTH-1:0]      count_q,  count_d;
  logic [BOX_WIDTH-1:0]  caixas_q, caixas_d;
  logic [LOSS_WIDTH-1:0] perdas_q, perdas_d;
  logic                  duzia_q,  duzia_d;
  logic                  lote_q,   lote_d;

  logic ultima;
  logic box_pending;
  logic entrada_pronta;
  logic aceita;
  logic rejeita;
  logic fecha;
  logic fecha_lote;

  // ---------------------------------------------------------------------------
  // Acceptance decode
  // ---------------------------------------------------------------------------
  // The line only stalls on the closing bottle when the previous box is still
  // unclaimed; an ACK in the same cycle frees the slot in time.
  always_comb begin
    ultima         = (count_q == LAST_BOTTLE);
    box_pending    = (box_state == BOX_PENDING);
    entrada_pronta = !(ultima && box_pending && !bus.CAIXA_ACK);
    aceita         = bus.ENABLE &&  entrada_pronta && !bus.CLEAR;
    rejeita        = bus.ENABLE && !entrada_pronta && !bus.CLEAR;
    fecha          = aceita && ultima;
    fecha_lote     = fecha && (caixas_q == LAST_BOX);
  end

  // ---------------------------------------------------------------------------
  // Box hand-off FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    box_state_next = box_state;
    if (bus.CLEAR) begin
      box_state_next = BOX_IDLE;
    end else begin
      unique case (box_state)
        BOX_IDLE: begin
          if (fecha) box_state_next = BOX_PENDING;
        end
        BOX_PENDING: begin
          // A new closure keeps the slot full even if the old box was just taken.
          if (fecha)              box_state_next = BOX_PENDING;
          else if (bus.CAIXA_ACK) box_state_next = BOX_IDLE;
        end
        default: box_state_next = BOX_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      box_state <= BOX_IDLE;
    end else begin
      box_state <= box_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Counter next-state
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    count_d  = count_q;
    caixas_d = caixas_q;
    perdas_d = perdas_q;
    duzia_d  = 1'b0;
    lote_d   = 1'b0;

    if (bus.CLEAR) begin
      count_d  = '0;
      caixas_d = '0;
      perdas_d = '0;
    end else begin
      if (fecha) begin
        count_d  = '0;
        duzia_d  = 1'b1;
        lote_d   = fecha_lote;
        caixas_d = fecha_lote ? '0 : caixas_q + 1'b1;
      end else if (aceita) begin
        count_d = count_q + 1'b1;
      end

      if (rejeita && (perdas_q != LOSS_MAX)) begin
        perdas_d = perdas_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      count_q  <= '0;
      caixas_q <= '0;
      perdas_q <= '0;
      duzia_q  <= 1'b0;
      lote_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      caixas_q <= caixas_d;
      perdas_q <= perdas_d;
      duzia_q  <= duzia_d;
      lote_q   <= lote_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.ENTRADA_PRONTA = entrada_pronta;
  assign bus.COUNT          = count_q;
  assign bus.DUZIA_COMPLETA = duzia_q;
  assign bus.CAIXA_PRONTA   = box_pending;
  assign bus.CAIXAS         = caixas_q;
  assign bus.LOTE_COMPLETO  = lote_q;
  assign bus.PERDAS         = perdas_q;

endmodule

// File: tb/tb_contador_caixas_param.sv
// Scoreboard bench for contador_caixas_param: default, narrow-loss and
// small-pack instances driven by directed vectors.
module tb_contador_caixas_param;

  localparam int DEF = 0;
  localparam int SAT = 1;
  localparam int SML = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int tests    = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] caixas;
    logic       lote;
  } box_exp_t;

  box_exp_t q_def[$];
  box_exp_t q_sat[$];
  box_exp_t q_sml[$];

  int sat_exp[5] = '{1, 2, 3, 3, 3};

  contador_caixas_param_if #(.WIDTH(4), .BOX_WIDTH(8), .LOSS_WIDTH(8)) bd ();
  contador_caixas_param_if #(.WIDTH(4), .BOX_WIDTH(8), .LOSS_WIDTH(2)) bs ();
  contador_caixas_param_if #(.WIDTH(3), .BOX_WIDTH(8), .LOSS_WIDTH(8)) bm ();

  contador_caixas_param #(
    .WIDTH(4), .PACK_SIZE(12), .BOX_WIDTH(8), .LOT_SIZE(10), .LOSS_WIDTH(8)
  ) u_def (.CLOCK(clk), .RESET(rst_n), .bus(bd));

  contador_caixas_param #(
    .WIDTH(4), .PACK_SIZE(12), .BOX_WIDTH(8), .LOT_SIZE(10), .LOSS_WIDTH(2)
  ) u_sat (.CLOCK(clk), .RESET(rst_n), .bus(bs));

  contador_caixas_param #(
    .WIDTH(3), .PACK_SIZE(6), .BOX_WIDTH(8), .LOT_SIZE(1), .LOSS_WIDTH(8)
  ) u_sml (.CLOCK(clk), .RESET(rst_n), .bus(bm));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock with the given inputs, then strobes drop back to idle.
  task automatic cyc(input int which, input logic en, input logic ack, input logic clr);
    case (which)
      DEF:     begin bd.ENABLE = en; bd.CAIXA_ACK = ack; bd.CLEAR = clr; end
      SAT:     begin bs.ENABLE = en; bs.CAIXA_ACK = ack; bs.CLEAR = clr; end
      default: begin bm.ENABLE = en; bm.CAIXA_ACK = ack; bm.CLEAR = clr; end
    endcase
    tick();
    case (which)
      DEF:     begin bd.ENABLE = 1'b0; bd.CLEAR = 1'b0; end
      SAT:     begin bs.ENABLE = 1'b0; bs.CLEAR = 1'b0; end
      default: begin bm.ENABLE = 1'b0; bm.CLEAR = 1'b0; end
    endcase
  endtask

  task automatic expect_box(input int which, input int caixas, input logic lote);
    box_exp_t e;
    e.caixas = 8'(caixas);
    e.lote   = lote;
    case (which)
      DEF:     q_def.push_back(e);
      SAT:     q_sat.push_back(e);
      default: q_sml.push_back(e);
    endcase
  endtask

  task automatic check_box(input string tag, input box_exp_t e, input logic [31:0] caixas,
                           input logic lote, input logic duzia, input logic [31:0] count,
                           input logic pronta);
    check({tag, "_caixas"},  caixas,     32'(e.caixas));
    check({tag, "_lote"},    32'(lote),  32'(e.lote));
    check({tag, "_duzia"},   32'(duzia), 1);
    check({tag, "_count0"},  count,      0);
    check({tag, "_pronta"},  32'(pronta), 1);
  endtask

  task automatic unexpected_pulse(input string tag);
    tests++;
    failures++;
    $display("FAIL %s_unexpected_pulse: got a box pulse, expected none", tag);
  endtask

  // Monitor: every box/lot pulse must match the next queued expectation.
  box_exp_t mon_e;
  always @(negedge clk) begin
    if (bd.DUZIA_COMPLETA || bd.LOTE_COMPLETO) begin
      if (q_def.size() == 0) unexpected_pulse("def");
      else begin
        mon_e = q_def.pop_front();
        check_box("def", mon_e, 32'(bd.CAIXAS), bd.LOTE_COMPLETO, bd.DUZIA_COMPLETA,
                  32'(bd.COUNT), bd.CAIXA_PRONTA);
      end
    end
    if (bs.DUZIA_COMPLETA || bs.LOTE_COMPLETO) begin
      if (q_sat.size() == 0) unexpected_pulse("sat");
      else begin
        mon_e = q_sat.pop_front();
        check_box("sat", mon_e, 32'(bs.CAIXAS), bs.LOTE_COMPLETO, bs.DUZIA_COMPLETA,
                  32'(bs.COUNT), bs.CAIXA_PRONTA);
      end
    end
    if (bm.DUZIA_COMPLETA || bm.LOTE_COMPLETO) begin
      if (q_sml.size() == 0) unexpected_pulse("sml");
      else begin
        mon_e = q_sml.pop_front();
        check_box("sml", mon_e, 32'(bm.CAIXAS), bm.LOTE_COMPLETO, bm.DUZIA_COMPLETA,
                  32'(bm.COUNT), bm.CAIXA_PRONTA);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bd.ENABLE = 1'b0; bd.CLEAR = 1'b0; bd.CAIXA_ACK = 1'b0;
    bs.ENABLE = 1'b0; bs.CLEAR = 1'b0; bs.CAIXA_ACK = 1'b0;
    bm.ENABLE = 1'b0; bm.CLEAR = 1'b0; bm.CAIXA_ACK = 1'b0;
    #2;

    // Reset state
    check("rst_count",  32'(bd.COUNT), 0);
    check("rst_caixas", 32'(bd.CAIXAS), 0);
    check("rst_perdas", 32'(bd.PERDAS), 0);
    check("rst_pronta", 32'(bd.CAIXA_PRONTA), 0);
    check("rst_duzia",  32'(bd.DUZIA_COMPLETA), 0);
    check("rst_lote",   32'(bd.LOTE_COMPLETO), 0);
    check("rst_entrada_pronta", 32'(bd.ENTRADA_PRONTA), 1);
    tick();
    tick();
    rst_n = 1'b1;

    // One box with ACK high: COUNT 1..11 then 0, one pulse, CAIXAS 1
    for (int i = 1; i <= 12; i++) begin
      if (i == 12) expect_box(DEF, 1, 1'b0);
      cyc(DEF, 1'b1, 1'b1, 1'b0);
      check($sformatf("box1_count_%0d", i), 32'(bd.COUNT), (i == 12) ? 0 : i);
    end
    check("box1_duzia",  32'(bd.DUZIA_COMPLETA), 1);
    check("box1_caixas", 32'(bd.CAIXAS), 1);
    cyc(DEF, 1'b0, 1'b1, 1'b0);
    check("box1_duzia_single", 32'(bd.DUZIA_COMPLETA), 0);
    check("box1_ack_clears_pronta", 32'(bd.CAIXA_PRONTA), 0);

    // Full lot: 120 bottles, LOTE with the 10th box, CAIXAS back to 0
    cyc(DEF, 1'b0, 1'b1, 1'b1);
    check("lot_clear_caixas", 32'(bd.CAIXAS), 0);
    for (int k = 1; k <= 10; k++) begin
      for (int b = 1; b <= 12; b++) begin
        if (b == 12) expect_box(DEF, k % 10, k == 10);
        cyc(DEF, 1'b1, 1'b1, 1'b0);
      end
    end
    check("lot_lote", 32'(bd.LOTE_COMPLETO), 1);
    check("lot_caixas_after", 32'(bd.CAIXAS), 0);
    cyc(DEF, 1'b0, 1'b1, 1'b0);

    // Back-pressure
    cyc(DEF, 1'b0, 1'b0, 1'b1);
    for (int b = 1; b <= 12; b++) begin
      if (b == 12) expect_box(DEF, 1, 1'b0);
      cyc(DEF, 1'b1, 1'b0, 1'b0);
    end
    check("bp_pronta", 32'(bd.CAIXA_PRONTA), 1);
    for (int b = 1; b <= 11; b++) cyc(DEF, 1'b1, 1'b0, 1'b0);
    check("bp_count_stall", 32'(bd.COUNT), 11);
    check("bp_entrada_pronta", 32'(bd.ENTRADA_PRONTA), 0);
    for (int b = 1; b <= 3; b++) cyc(DEF, 1'b1, 1'b0, 1'b0);
    check("bp_perdas", 32'(bd.PERDAS), 3);
    check("bp_count_hold", 32'(bd.COUNT), 11);
    bd.CAIXA_ACK = 1'b1;
    bd.ENABLE    = 1'b1;
    #1;
    check("bp_ack_frees_stall", 32'(bd.ENTRADA_PRONTA), 1);
    expect_box(DEF, 2, 1'b0);
    tick();
    bd.ENABLE = 1'b0;
    check("bp_ack_close_count", 32'(bd.COUNT), 0);
    check("bp_ack_close_pronta", 32'(bd.CAIXA_PRONTA), 1);
    check("bp_ack_close_perdas", 32'(bd.PERDAS), 3);
    cyc(DEF, 1'b0, 1'b1, 1'b0);
    check("bp_ack_handoff", 32'(bd.CAIXA_PRONTA), 0);

    // CLEAR from COUNT=7, CAIXAS=4, PERDAS=2 with ENABLE high
    cyc(DEF, 1'b0, 1'b1, 1'b1);
    for (int b = 1; b <= 36; b++) begin
      if (b % 12 == 0) expect_box(DEF, b / 12, 1'b0);
      cyc(DEF, 1'b1, 1'b1, 1'b0);
    end
    for (int b = 1; b <= 11; b++) cyc(DEF, 1'b1, 1'b0, 1'b0);
    for (int b = 1; b <= 2; b++)  cyc(DEF, 1'b1, 1'b0, 1'b0);
    expect_box(DEF, 4, 1'b0);
    cyc(DEF, 1'b1, 1'b1, 1'b0);
    for (int b = 1; b <= 7; b++) cyc(DEF, 1'b1, 1'b1, 1'b0);
    check("clr_pre_count",  32'(bd.COUNT), 7);
    check("clr_pre_caixas", 32'(bd.CAIXAS), 4);
    check("clr_pre_perdas", 32'(bd.PERDAS), 2);
    cyc(DEF, 1'b1, 1'b1, 1'b1);
    check("clr_count",  32'(bd.COUNT), 0);
    check("clr_caixas", 32'(bd.CAIXAS), 0);
    check("clr_perdas", 32'(bd.PERDAS), 0);
    check("clr_pronta", 32'(bd.CAIXA_PRONTA), 0);
    check("clr_duzia",  32'(bd.DUZIA_COMPLETA), 0);
    check("clr_lote",   32'(bd.LOTE_COMPLETO), 0);

    // Asynchronous reset mid-box with a pending box
    for (int b = 1; b <= 12; b++) begin
      if (b == 12) expect_box(DEF, 1, 1'b0);
      cyc(DEF, 1'b1, 1'b0, 1'b0);
    end
    for (int b = 1; b <= 5; b++) cyc(DEF, 1'b1, 1'b0, 1'b0);
    check("arst_pre_count", 32'(bd.COUNT), 5);
    check("arst_pre_pronta", 32'(bd.CAIXA_PRONTA), 1);
    rst_n = 1'b0;
    #1;
    check("arst_count",  32'(bd.COUNT), 0);
    check("arst_caixas", 32'(bd.CAIXAS), 0);
    check("arst_pronta", 32'(bd.CAIXA_PRONTA), 0);
    check("arst_duzia",  32'(bd.DUZIA_COMPLETA), 0);
    check("arst_lote",   32'(bd.LOTE_COMPLETO), 0);
    check("arst_entrada_pronta", 32'(bd.ENTRADA_PRONTA), 1);
    tick();
    tick();
    rst_n = 1'b1;
    cyc(DEF, 1'b1, 1'b0, 1'b0);
    check("arst_first_bottle", 32'(bd.COUNT), 1);

    // Loss saturation with LOSS_WIDTH=2
    for (int b = 1; b <= 12; b++) begin
      if (b == 12) expect_box(SAT, 1, 1'b0);
      cyc(SAT, 1'b1, 1'b0, 1'b0);
    end
    for (int b = 1; b <= 11; b++) cyc(SAT, 1'b1, 1'b0, 1'b0);
    check("sat_entrada_pronta", 32'(bs.ENTRADA_PRONTA), 0);
    for (int r = 0; r < 5; r++) begin
      cyc(SAT, 1'b1, 1'b0, 1'b0);
      check($sformatf("sat_perdas_%0d", r + 1), 32'(bs.PERDAS), 32'(sat_exp[r]));
    end
    check("sat_count_hold", 32'(bs.COUNT), 11);

    // PACK_SIZE=6, LOT_SIZE=1: every box is also a lot
    for (int b = 1; b <= 18; b++) begin
      if (b % 6 == 0) expect_box(SML, 0, 1'b1);
      cyc(SML, 1'b1, 1'b1, 1'b0);
      check($sformatf("sml_count_%0d", b), 32'(bm.COUNT), b % 6);
      check($sformatf("sml_caixas_%0d", b), 32'(bm.CAIXAS), 0);
    end

    tick();
    tick();
    check("def_queue_drained", 32'(q_def.size()), 0);
    check("sat_queue_drained", 32'(q_sat.size()), 0);
    check("sml_queue_drained", 32'(q_sml.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/contador_caixas_param.md
# contador_caixas_param

Parametrised bottle-packing counter for the wine bottling line: counts accepted bottles into boxes of `PACK_SIZE`, closes each box with a handshake to the packaging stage, counts closed boxes into lots of `LOT_SIZE`, and counts bottles lost when the line is back-pressured. It is the next-generation replacement for the fixed dozen counter. It sits between the bottle sensor and the box-sealing controller.

## Interface
- `WIDTH`, 4: bottle-count width; requires `2 <= PACK_SIZE <= 2^WIDTH`.
- `PACK_SIZE`, 12: bottles per box.
- `BOX_WIDTH`, 8: box-count width; requires `1 <= LOT_SIZE <= 2^BOX_WIDTH`.
- `LOT_SIZE`, 10: boxes per lot.
- `LOSS_WIDTH`, 8: width of the lost-bottle counter.

Ports:
- `CLOCK` in 1: single clock, rising edge.
- `RESET` in 1: asynchronous, active-low reset.
- `ENABLE` in 1: bottle-present strobe; at most one bottle per cycle.
- `CLEAR` in 1: synchronous clear of all state; has priority over everything except `RESET`.
- `CAIXA_ACK` in 1: the sealing stage has taken the pending box.
- `ENTRADA_PRONTA` out 1: a bottle can be accepted this cycle (combinational).
- `COUNT` out `WIDTH`: bottles in the current box.
- `DUZIA_COMPLETA` out 1: one-cycle registered pulse when a box closes.
- `CAIXA_PRONTA` out 1: a closed box is waiting for `CAIXA_ACK`.
- `CAIXAS` out `BOX_WIDTH`: boxes closed in the current lot.
- `LOTE_COMPLETO` out 1: one-cycle registered pulse when a lot closes.
- `PERDAS` out `LOSS_WIDTH`: rejected bottles; saturates at all-ones.

## Operation
- Define `ultima = (COUNT == PACK_SIZE-1)`.
- `ENTRADA_PRONTA = !(ultima && CAIXA_PRONTA && !CAIXA_ACK)`. A same-cycle ACK frees the stall.
- `aceita = ENABLE && ENTRADA_PRONTA && !CLEAR`.
- `rejeita = ENABLE && !ENTRADA_PRONTA && !CLEAR`.
- On `aceita` with `!ultima`: `COUNT` increments by 1.
- On `aceita` with `ultima`, a box closes:
  - `COUNT` goes to 0.
  - `DUZIA_COMPLETA` is 1 in the next cycle only.
  - `CAIXA_PRONTA` is set to 1.
  - `CAIXAS` increments. If `CAIXAS == LOT_SIZE-1`, `CAIXAS` goes to 0 and `LOTE_COMPLETO` pulses in the same cycle as `DUZIA_COMPLETA`.
- `CAIXA_PRONTA` handling:
  - It clears on a cycle where `CAIXA_ACK` is high and no box closes.
  - If a box closes while `CAIXA_PRONTA` is high and `CAIXA_ACK` is high, it stays 1: the old box is handed off and the new box is pending.
  - `CAIXA_ACK` while `CAIXA_PRONTA` is 0 is ignored.
- On `rejeita`: `PERDAS` increments unless all-ones. `COUNT`, `CAIXAS` and `CAIXA_PRONTA` are unchanged.
- `CLEAR`:
  - `COUNT`, `CAIXAS` and `PERDAS` go to 0.
  - `CAIXA_PRONTA`, `DUZIA_COMPLETA` and `LOTE_COMPLETO` go to 0.
  - `ENABLE` in the same cycle is dropped and not counted as a loss.
- Boxes are counted at closure, not at acknowledge.
- All counters wrap exactly at their limits; values at or above the limit are unreachable.

## Timing
- `RESET` low forces all registered outputs to 0 immediately, independent of `CLOCK`: `COUNT`, `CAIXAS`, `PERDAS`, `CAIXA_PRONTA`, `DUZIA_COMPLETA`, `LOTE_COMPLETO`.
- While in reset, `ENTRADA_PRONTA` is 1.
- Release of `RESET` is synchronous to `CLOCK` by the system reset bridge. The first edge after release can accept a bottle.
- Reset mid-box discards the partial box and any pending box. No pulse is emitted.
- Latency: `COUNT` reflects a bottle one cycle after the accepting edge.
- `DUZIA_COMPLETA`, `LOTE_COMPLETO` and `CAIXA_PRONTA` are visible in the cycle after the closing edge.
- Back-to-back pulses:
  - `DUZIA_COMPLETA` can recur no sooner than `PACK_SIZE` cycles apart.
  - `LOTE_COMPLETO` can recur no sooner than `PACK_SIZE*LOT_SIZE` cycles apart.
- Stall: while `ENTRADA_PRONTA` is 0, `COUNT` holds at `PACK_SIZE-1` indefinitely.
- Simultaneous closing bottle and `CAIXA_ACK`: the bottle is accepted and `CAIXA_PRONTA` stays 1.

## Test plan
- Reset, then 12 consecutive `ENABLE` cycles with `CAIXA_ACK` held high (defaults):
  - `COUNT` steps 1..11, then 0.
  - `DUZIA_COMPLETA` pulses once, in the cycle after the 12th bottle.
  - `CAIXAS` reads 1.
- 120 bottles with `CAIXA_ACK` high:
  - 10 `DUZIA_COMPLETA` pulses.
  - `LOTE_COMPLETO` coincides with the 10th pulse.
  - `CAIXAS` reads 0 afterwards.
- Back-pressure:
  - 12 bottles with `CAIXA_ACK` low, then 11 more: `COUNT` is 11 and `ENTRADA_PRONTA` is 0.
  - 3 further `ENABLE` cycles: `PERDAS` is 3 and `COUNT` stays 11.
  - Raise `CAIXA_ACK` together with a bottle: it is accepted and `CAIXA_PRONTA` remains 1.
- With `LOSS_WIDTH=2`, 5 rejected bottles: `PERDAS` saturates at 3.
- `CLEAR`:
  - Assert with `COUNT=7`, `CAIXAS=4`, `PERDAS=2` and `ENABLE` high: all read 0 next cycle and `PERDAS` does not increment.
  - Repeat with `RESET` low mid-box: outputs go to 0 before the next `CLOCK` edge.
- Parameter sweep `PACK_SIZE=6`, `WIDTH=3`, `LOT_SIZE=1`:
  - Every 6th bottle produces both `DUZIA_COMPLETA` and `LOTE_COMPLETO`.
  - `CAIXAS` stays 0.
